cdc_led_cmd: RTL and testbench

CDC_LED_CMD -- requirements
Module: cdc_led_cmd

---
 rtl/cdc_led_cmd.sv | 120 ++++++++++++
 tb/tb_cdc_led_cmd.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cdc_led_cmd.sv
// cdc_led_cmd: byte-stream command parser for an RGB LED; 'L' r g b sets duties, '?' reads them back.
// Drives three PWM enables from the committed duties.
module cdc_led_cmd #(
    parameter int unsigned PWM_DIV = 16,
    parameter logic [31:0] TIMEOUT = 32'd48000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] out_data_i,
    input  logic       out_valid_i,
    output logic       out_ready_o,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i,
    output logic [2:0] led_o
);
    typedef enum logic [2:0] {IDLE, ARG_R, ARG_G, ARG_B, RESP} state_t;
    localparam logic [15:0] PRE_LAST = 16'(PWM_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
    logic [7:0]  shadow_r_q, shadow_r_d, shadow_g_q, shadow_g_d, shadow_b_q, shadow_b_d;
    logic [23:0] resp_q, resp_d;
    logic [1:0]  resp_cnt_q, resp_cnt_d;
    logic [31:0] idle_q, idle_d;
    logic [7:0]  pwm_q, pwm_d;
    logic [15:0] pre_q, pre_d;
    logic [2:0]  led_q, led_d;
    logic        out_acc, in_acc, in_arg;

    assign out_ready_o = state_q != RESP;
    assign in_valid_o  = state_q == RESP;
    assign in_data_o   = resp_q[23:16];
    assign led_o       = led_q;
    assign out_acc     = out_valid_i && out_ready_o;
    assign in_acc      = in_valid_o && in_ready_i;
    assign in_arg      = state_q == ARG_R || state_q == ARG_G || state_q == ARG_B;

    always_comb begin
        state_d    = state_q;
        duty_r_d   = duty_r_q;
        duty_g_d   = duty_g_q;
        duty_b_d   = duty_b_q;
        shadow_r_d = shadow_r_q;
        shadow_g_d = shadow_g_q;
        shadow_b_d = shadow_b_q;
        resp_d     = resp_q;
        resp_cnt_d = resp_cnt_q;
        pre_d      = (pre_q == PRE_LAST) ? 16'd0 : pre_q + 16'd1;
        pwm_d      = (pre_q == PRE_LAST) ? pwm_q + 8'd1 : pwm_q;
        led_d      = {pwm_q < duty_b_q, pwm_q < duty_g_q, pwm_q < duty_r_q};
        // Idle counter only runs inside an argument frame and restarts on every accepted byte.
        idle_d     = (in_arg && !out_acc) ? idle_q + 32'd1 : 32'd0;
        case (state_q)
            IDLE: if (out_acc) begin
                state_d    = (out_data_i == 8'h4C) ? ARG_R : RESP;
                resp_d     = (out_data_i == 8'h3F) ? {duty_r_q, duty_g_q, duty_b_q} : 24'h210000;
                resp_cnt_d = (out_data_i == 8'h3F) ? 2'd3 : 2'd1;
            end
            ARG_R, ARG_G, ARG_B: if (out_acc) begin
                shadow_r_d = (state_q == ARG_R) ? out_data_i : shadow_r_q;
                shadow_g_d = (state_q == ARG_G) ? out_data_i : shadow_g_q;
                shadow_b_d = (state_q == ARG_B) ? out_data_i : shadow_b_q;
                state_d    = (state_q == ARG_R) ? ARG_G : (state_q == ARG_G) ? ARG_B : RESP;
                if (state_q == ARG_B) begin
                    duty_r_d   = shadow_r_q;
                    duty_g_d   = shadow_g_q;
                    duty_b_d   = out_data_i;
                    resp_d     = 24'h4B0000;
                    resp_cnt_d = 2'd1;
                end
            end else if (idle_q >= TIMEOUT - 32'd1) begin
                shadow_r_d = 8'd0;
                shadow_g_d = 8'd0;
                shadow_b_d = 8'd0;
                resp_d     = 24'h210000;
                resp_cnt_d = 2'd1;
                state_d    = RESP;
            end
            RESP: if (in_acc) begin
                resp_d     = resp_q << 8;
                resp_cnt_d = resp_cnt_q - 2'd1;
                state_d    = (resp_cnt_q == 2'd1) ? IDLE : RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            duty_r_q   <= '0;
            duty_g_q   <= '0;
            duty_b_q   <= '0;
            shadow_r_q <= '0;
            shadow_g_q <= '0;
            shadow_b_q <= '0;
            resp_q     <= '0;
            resp_cnt_q <= '0;
            idle_q     <= '0;
            pwm_q      <= '0;
            pre_q      <= '0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            duty_r_q   <= duty_r_d;
            duty_g_q   <= duty_g_d;
            duty_b_q   <= duty_b_d;
            shadow_r_q <= shadow_r_d;
            shadow_g_q <= shadow_g_d;
            shadow_b_q <= shadow_b_d;
            resp_q     <= resp_d;
            resp_cnt_q <= resp_cnt_d;
            idle_q     <= idle_d;
            pwm_q      <= pwm_d;
            pre_q      <= pre_d;
            led_q      <= led_d;
        end
    end
endmodule

// File: tb/tb_cdc_led_cmd.sv
// tb_cdc_led_cmd: directed and randomized command traffic checked against a duty/response model.
module tb_cdc_led_cmd;
    logic       clk = 0;
    logic       rstn = 0;
    logic [7:0] out_data_i = 0;
    logic       out_valid_i = 0;
    logic       out_ready_o;
    logic [7:0] in_data_o;
    logic       in_valid_o;
    logic       in_ready_i = 0;
    logic [2:0] led_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] m_duty [3];

    cdc_led_cmd #(.PWM_DIV(1), .TIMEOUT(32'd100)) dut (
        .clk(clk), .rstn(rstn),
        .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
        .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
        .led_o(led_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        out_valid_i = 1;
        out_data_i  = b;
        while (!out_ready_o && n < 1000) begin
            tick(1);
            n++;
        end
        check("send_ready", 32'(out_ready_o), 32'd1);
        tick(1);
        out_valid_i = 0;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp, input int stall);
        int n = 0;
        in_ready_i = 0;
        tick(stall);
        in_ready_i = 1;
        while (!in_valid_o && n < 1000) begin
            tick(1);
            n++;
        end
        check({tag, "_valid"}, 32'(in_valid_o), 32'd1);
        check({tag, "_data"}, 32'(in_data_o), 32'(exp));
        tick(1);
        in_ready_i = 0;
    endtask

    task automatic set_duty(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input int gap);
        send(8'h4C);
        tick(gap);
        send(r);
        tick(gap);
        send(g);
        tick(gap);
        send(b);
        m_duty[0] = r;
        m_duty[1] = g;
        m_duty[2] = b;
        expect_byte("ack", 8'h4B, $urandom_range(0, 3));
    endtask

    task automatic query(input int stall);
        send(8'h3F);
        for (int i = 0; i < 3; i++) expect_byte("query", m_duty[i], stall);
    endtask

    // With PWM_DIV = 1 every 256 consecutive cycles visit each counter value once.
    task automatic pwm_check();
        int hi [3];
        hi = '{0, 0, 0};
        tick(4);
        repeat (256) begin
            tick(1);
            for (int c = 0; c < 3; c++) hi[c] += int'(led_o[c]);
        end
        for (int c = 0; c < 3; c++) check("pwm_high_count", 32'(hi[c]), 32'(m_duty[c]));
    endtask

    initial begin
        m_duty = '{8'd0, 8'd0, 8'd0};
        #12;
        check("rst_led", 32'(led_o), 32'd0);
        check("rst_in_valid", 32'(in_valid_o), 32'd0);
        check("rst_in_data", 32'(in_data_o), 32'd0);
        check("rst_out_ready", 32'(out_ready_o), 32'd1);
        @(negedge clk);
        rstn = 1;
        tick(2);

        set_duty(8'h80, 8'h40, 8'hFF, 0);
        pwm_check();

        send(8'h3F);
        in_ready_i = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("stall_valid", 32'(in_valid_o), 32'd1);
            check("stall_data", 32'(in_data_o), 32'h80);
        end
        for (int i = 0; i < 3; i++) expect_byte("query", m_duty[i], 0);

        send(8'h55);
        tick(2);
        check("bad_ready_low", 32'(out_ready_o), 32'd0);
        expect_byte("bad", 8'h21, 0);
        check("bad_ready_back", 32'(out_ready_o), 32'd1);
        query(1);

        send(8'h4C);
        send(8'h10);
        tick(90);
        check("timeout_not_yet", 32'(in_valid_o), 32'd0);
        expect_byte("timeout", 8'h21, 0);
        query(0);

        set_duty(8'h00, 8'hFF, 8'h01, 2);
        pwm_check();

        send(8'h4C);
        send(8'h11);
        send(8'h22);
        @(negedge clk);
        rstn = 0;
        #2;
        check("midrst_led", 32'(led_o), 32'd0);
        check("midrst_in_valid", 32'(in_valid_o), 32'd0);
        check("midrst_out_ready", 32'(out_ready_o), 32'd1);
        @(negedge clk);
        rstn = 1;
        m_duty = '{8'd0, 8'd0, 8'd0};
        tick(1);
        check("postrst_in_valid", 32'(in_valid_o), 32'd0);
        query(0);

        for (int it = 0; it < 30; it++) begin
            int kind = $urandom_range(0, 2);
            if (kind == 0) begin
                set_duty(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 20));
                pwm_check();
            end else if (kind == 1) begin
                query($urandom_range(0, 4));
            end else begin
                logic [7:0] b = 8'($urandom);
                if (b == 8'h4C || b == 8'h3F) b = 8'h55;
                send(b);
                expect_byte("other", 8'h21, $urandom_range(0, 4));
            end
        end
        query(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
